// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding Wishbone pipelined command master
//
// Takes one command on a valid/ready port, runs exactly one Wishbone cycle,
// and returns the outcome (data, err/rty, timeout) on a valid/ready port.
//
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake (ready only while idle)
//   cmd_we_i/adr_i/sel_i/dat_i  command fields, captured on accept
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_dat_o/err_o/timeout_o   outcome, held stable until consumed
//   wb_*                     Wishbone pipelined master port
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [3:0]            cmd_sel_i,
  input  logic [31:0]           cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cyc_d, stb_d, we_d;
  logic [ADDR_WIDTH-1:0] adr_d;
  logic [3:0]            sel_d;
  logic [31:0]           wdat_d;
  logic                  rsp_valid_d, rsp_err_d, rsp_to_d;
  logic [31:0]           rsp_dat_d;

  // Bus inputs only mean something while our cycle is open; this is what
  // drops late acks arriving after a timeout.
  logic term, fail, cnt_hit;
  assign term    = wb_cyc_o & (wb_ack_i | wb_err_i | wb_rty_i);
  assign fail    = wb_cyc_o & (wb_err_i | wb_rty_i);
  assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT));

  // Gated by reset so the port reads 0 while reset is held.
  assign cmd_ready_o = rst_n_i & (state_q == S_IDLE);

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_adr_o      <= '0;
      wb_sel_o      <= '0;
      wb_dat_o      <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wb_cyc_o      <= cyc_d;
      wb_stb_o      <= stb_d;
      wb_we_o       <= we_d;
      wb_adr_o      <= adr_d;
      wb_sel_o      <= sel_d;
      wb_dat_o      <= wdat_d;
      rsp_valid_o   <= rsp_valid_d;
      rsp_dat_o     <= rsp_dat_d;
      rsp_err_o     <= rsp_err_d;
      rsp_timeout_o <= rsp_to_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid_i) state_d = S_REQ;
      S_REQ: begin
        if (term || cnt_hit) state_d = S_RSP;
        else if (!wb_stall_i) state_d = S_WAIT;
      end
      S_WAIT: if (term || cnt_hit) state_d = S_RSP;
      S_RSP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    cyc_d       = wb_cyc_o;
    stb_d       = wb_stb_o;
    we_d        = wb_we_o;
    adr_d       = wb_adr_o;
    sel_d       = wb_sel_o;
    wdat_d      = wb_dat_o;
    rsp_valid_d = rsp_valid_o;
    rsp_dat_d   = rsp_dat_o;
    rsp_err_d   = rsp_err_o;
    rsp_to_d    = rsp_timeout_o;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          we_d   = cmd_we_i;
          adr_d  = cmd_adr_i;
          sel_d  = cmd_sel_i;
          wdat_d = cmd_dat_i;
          cyc_d  = 1'b1;
          stb_d  = 1'b1;
          cnt_d  = CNT_W'(1);
        end
      end
      S_REQ, S_WAIT: begin
        // Termination has priority over the timeout in the same cycle.
        if (term) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = fail;
          rsp_dat_d   = (fail || wb_we_o) ? 32'h0 : wb_dat_i;
          cnt_d       = '0;
        end else if (cnt_hit) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_to_d    = 1'b1;
          rsp_dat_d   = 32'h0;
          cnt_d       = '0;
        end else begin
          // Cannot wrap: reaching TIMEOUT always leaves this state.
          cnt_d = cnt_q + CNT_W'(1);
          if (!wb_stall_i) stb_d = 1'b0;
        end
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b0;
          rsp_to_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [7:0]  cmd_adr = '0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_dat = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [31:0] rsp_dat;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.ADDR_WIDTH(8), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
  );

  // Stub register bank: stalls cfg_s cycles, answers cfg_d cycles after
  // accepting stb. cfg_k: 0 ack, 1 err, 2 rty, 3 err+ack, 4 never answers.
  int          cfg_s = 1, cfg_d = 0, cfg_k = 0;
  logic        inj_ack = 1'b0;
  logic [31:0] mem [16];
  int          st_cnt, dly;
  logic        pend, sl_stall, sl_resp;
  logic [31:0] wmask;

  assign sl_stall   = wb_cyc_o && wb_stb_o && (st_cnt < cfg_s);
  assign sl_resp    = wb_cyc_o && ((wb_stb_o && !sl_stall && cfg_d == 0) || (pend && dly == 0));
  assign wb_stall_i = sl_stall;
  assign wb_ack_i   = (sl_resp && (cfg_k == 0 || cfg_k == 3)) || inj_ack;
  assign wb_err_i   = sl_resp && (cfg_k == 1 || cfg_k == 3);
  assign wb_rty_i   = sl_resp && cfg_k == 2;
  assign wb_dat_i   = (sl_resp || inj_ack) ? mem[wb_adr_o[5:2]] : 32'hDEADBEEF;
  assign wmask      = {{8{wb_sel_o[3]}}, {8{wb_sel_o[2]}}, {8{wb_sel_o[1]}}, {8{wb_sel_o[0]}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_cnt <= 0;
      dly    <= 0;
      pend   <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 32'h0000000C : 32'h100 + i;
    end else if (!wb_cyc_o) begin
      st_cnt <= 0;
      pend   <= 1'b0;
    end else begin
      if (wb_stb_o && sl_stall) st_cnt <= st_cnt + 1;
      if (wb_stb_o && !sl_stall) begin
        st_cnt <= 0;
        if (cfg_d != 0) begin
          pend <= 1'b1;
          dly  <= cfg_d - 1;
        end
      end else if (pend && dly != 0) begin
        dly <= dly - 1;
      end
      if (pend && sl_resp) pend <= 1'b0;
      if (sl_resp && cfg_k == 0 && wb_we_o)
        mem[wb_adr_o[5:2]] <= (mem[wb_adr_o[5:2]] & ~wmask) | (wb_dat_o & wmask);
    end
  end

  // Reference model: outcome of one command from the timing rules alone.
  logic [31:0] ref_mem [16];

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = (i == 0) ? 32'h0000000C : 32'h100 + i;
  endtask

  task automatic model(input bit we, input logic [7:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input int s, input int d, input int k,
                       output logic [31:0] e_dat, output bit e_err, output bit e_to,
                       output int e_lat, output int e_stb, output int e_cyc);
    int t;
    logic [31:0] m;
    t     = (k == 4) ? 1000 : 1 + s + d;
    e_to  = t > TO;
    e_cyc = e_to ? TO : t;
    e_lat = e_cyc + 1;
    e_stb = (s + 1 < TO) ? s + 1 : TO;
    e_err = !e_to && k != 0;
    e_dat = (!e_to && k == 0 && !we) ? ref_mem[adr[5:2]] : 32'h0;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    if (!e_to && k == 0 && we) ref_mem[adr[5:2]] = (ref_mem[adr[5:2]] & ~m) | (dat & m);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one command and collects the response; side_ok covers
  // cmd_ready gating, response stability under back-pressure and the
  // post-handshake return to idle.
  task automatic run_cmd(input bit we, input logic [7:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input int s, input int d, input int k,
                         input int hold, input bit poke,
                         output logic [31:0] r_dat, output bit r_err, output bit r_to,
                         output int lat, output int stbn, output int cycn, output bit side_ok);
    cfg_s = s; cfg_d = d; cfg_k = k;
    side_ok = 1'b1;
    @(negedge clk);
    if (!cmd_ready) side_ok = 1'b0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; stbn = 0; cycn = 0;
    for (int c = 1; c <= 100; c++) begin
      if (rsp_valid) begin
        lat = c;
        break;
      end
      stbn += int'(wb_stb_o);
      cycn += int'(wb_cyc_o);
      if (cmd_ready) side_ok = 1'b0;
      @(negedge clk);
    end
    r_dat = rsp_dat; r_err = rsp_err; r_to = rsp_timeout;
    if (lat != 0) begin
      for (int h = 0; h < hold; h++) begin
        if (poke) begin
          cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 8'h3C; cmd_dat = $urandom;
        end
        if (cmd_ready || wb_cyc_o || !rsp_valid || rsp_dat !== r_dat ||
            rsp_err !== r_err || rsp_timeout !== r_to) side_ok = 1'b0;
        @(negedge clk);
      end
      cmd_valid = 1'b0;
      if (cmd_ready || !rsp_valid || rsp_dat !== r_dat) side_ok = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      if (rsp_valid || !cmd_ready || wb_cyc_o) side_ok = 1'b0;
    end
  endtask

  typedef struct {
    bit          we;
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          s, d, k;
    logic [31:0] e_dat;
    bit          e_err, e_to;
    int          e_lat;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] r_dat, m_dat;
    bit          r_err, r_to, side_ok, m_err, m_to;
    int          lat, stbn, cycn, m_lat, m_stb, m_cyc;

    vecs[0]  = '{1'b0, 8'h00, 4'hF, 32'h0,        1, 0,  0, 32'h0000000C, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b1, 8'h00, 4'hF, 32'h00000005, 1, 0,  0, 32'h0,        1'b0, 1'b0, 3};
    vecs[2]  = '{1'b0, 8'h00, 4'hF, 32'h0,        1, 0,  0, 32'h00000005, 1'b0, 1'b0, 3};
    vecs[3]  = '{1'b1, 8'h04, 4'h5, 32'hAABBCCDD, 0, 2,  0, 32'h0,        1'b0, 1'b0, 4};
    vecs[4]  = '{1'b0, 8'h04, 4'hF, 32'h0,        2, 1,  0, 32'h00BB01DD, 1'b0, 1'b0, 5};
    vecs[5]  = '{1'b0, 8'h00, 4'hF, 32'h0,        0, 2,  3, 32'h0,        1'b1, 1'b0, 4};
    vecs[6]  = '{1'b0, 8'h00, 4'hF, 32'h0,        0, 1,  2, 32'h0,        1'b1, 1'b0, 3};
    vecs[7]  = '{1'b0, 8'h00, 4'hF, 32'h0,        0, 0,  1, 32'h0,        1'b1, 1'b0, 2};
    vecs[8]  = '{1'b1, 8'h00, 4'hF, 32'hFFFFFFFF, 0, 1,  1, 32'h0,        1'b1, 1'b0, 3};
    vecs[9]  = '{1'b0, 8'h00, 4'hF, 32'h0,        3, 11, 0, 32'h00000005, 1'b0, 1'b0, 16};
    vecs[10] = '{1'b0, 8'h00, 4'hF, 32'h0,        3, 12, 0, 32'h0,        1'b0, 1'b1, 16};
    vecs[11] = '{1'b0, 8'h00, 4'hF, 32'h0,        0, 0,  4, 32'h0,        1'b0, 1'b1, 16};
    vecs[12] = '{1'b0, 8'h00, 4'hF, 32'h0,        15, 0, 0, 32'h0,        1'b0, 1'b1, 16};
    vecs[13] = '{1'b0, 8'h08, 4'hF, 32'h0,        1, 0,  0, 32'h00000102, 1'b0, 1'b0, 3};

    // Reset state
    ref_reset();
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {31'h0, cmd_ready | rsp_valid | rsp_err | rsp_timeout | wb_cyc_o | wb_stb_o | wb_we_o}, 32'h0);
    chk("reset_bus", {20'h0, wb_adr_o, wb_sel_o} | wb_dat_o | rsp_dat, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, cmd_ready}, 32'h1);

    // Directed table
    foreach (vecs[i]) begin
      run_cmd(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].s, vecs[i].d,
              vecs[i].k, 0, 1'b0, r_dat, r_err, r_to, lat, stbn, cycn, side_ok);
      model(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].s, vecs[i].d,
            vecs[i].k, m_dat, m_err, m_to, m_lat, m_stb, m_cyc);
      chk($sformatf("vec%0d_dat", i), r_dat, vecs[i].e_dat);
      chk($sformatf("vec%0d_err", i), {31'h0, r_err}, {31'h0, vecs[i].e_err});
      chk($sformatf("vec%0d_timeout", i), {31'h0, r_to}, {31'h0, vecs[i].e_to});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].e_lat);
      chk($sformatf("vec%0d_stb_cycles", i), stbn, m_stb);
      chk($sformatf("vec%0d_cyc_cycles", i), cycn, m_cyc);
      chk($sformatf("vec%0d_handshake", i), {31'h0, side_ok}, 32'h1);
    end
    chk("fa_1", mem[0], 32'h00000005);

    // Timeout followed by a late ack that must be dropped
    run_cmd(1'b0, 8'h00, 4'hF, 32'h0, 0, 0, 4, 0, 1'b0, r_dat, r_err, r_to, lat, stbn, cycn, side_ok);
    chk("late_timeout", {31'h0, r_to}, 32'h1);
    chk("late_cyc_cycles", cycn, TO);
    @(negedge clk);
    inj_ack = 1'b1;
    @(negedge clk);
    inj_ack = 1'b0;
    side_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid || !cmd_ready || wb_cyc_o) side_ok = 1'b0;
      @(negedge clk);
    end
    chk("late_ack_dropped", {31'h0, side_ok}, 32'h1);

    // Response back-pressure with a competing command presented
    run_cmd(1'b0, 8'h04, 4'hF, 32'h0, 1, 0, 0, 10, 1'b1, r_dat, r_err, r_to, lat, stbn, cycn, side_ok);
    chk("bp_dat", r_dat, ref_mem[1]);
    chk("bp_stable", {31'h0, side_ok}, 32'h1);
    chk("bp_not_written", mem[15], 32'h10F);

    // Randomised traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      bit          we;
      logic [7:0]  adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      int          s, d, k, r;
      we  = 1'($urandom);
      adr = 8'($urandom_range(0, 3) * 4);
      sel = 4'($urandom_range(1, 15));
      dat = $urandom;
      s   = $urandom_range(0, 4);
      d   = $urandom_range(0, 4);
      r   = $urandom_range(0, 19);
      k   = (r < 13) ? 0 : (r < 18) ? r - 14 : 4;
      if (k < 0) k = 1;
      if (r == 19 && i % 2 == 0) begin
        k = 0;
        s = $urandom_range(13, 16);
      end
      model(we, adr, sel, dat, s, d, k, m_dat, m_err, m_to, m_lat, m_stb, m_cyc);
      run_cmd(we, adr, sel, dat, s, d, k, $urandom_range(0, 3), 1'b0,
              r_dat, r_err, r_to, lat, stbn, cycn, side_ok);
      chk($sformatf("rnd%0d_dat", i), r_dat, m_dat);
      chk($sformatf("rnd%0d_flags", i), {30'h0, r_err, r_to}, {30'h0, m_err, m_to});
      chk($sformatf("rnd%0d_latency", i), lat, m_lat);
      chk($sformatf("rnd%0d_stb_cyc", i), {stbn[15:0], cycn[15:0]}, {m_stb[15:0], m_cyc[15:0]});
      chk($sformatf("rnd%0d_handshake", i), {31'h0, side_ok}, 32'h1);
    end

    // Reset asserted while waiting on a silent slave
    cfg_s = 0; cfg_d = 0; cfg_k = 4;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 8'h00; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_wait", {30'h0, wb_cyc_o, wb_stb_o}, 32'h2);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {28'h0, wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_reset();
    run_cmd(1'b0, 8'h00, 4'hF, 32'h0, 1, 0, 0, 0, 1'b0, r_dat, r_err, r_to, lat, stbn, cycn, side_ok);
    chk("post_reset_read", r_dat, 32'h0000000C);
    chk("post_reset_latency", lat, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
